div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Multi-cycle sequencer for 32-bit DIV/DIVU in the execute stage, alongside the single-cycle alu.
- Accepts operands from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline stalled until the result is ready.
- Delivers {HI=remainder, LO=quotient} for the hilo register write.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  divide request; held high by EX until ready_o is seen.
annul_i  input  1  flush/exception; aborts the current operation.
signed_div_i  input  1  1 = DIV, 0 = DIVU; sampled with start_i.
opdata1_i  input  WIDTH  dividend; sampled with start_i.
opdata2_i  input  WIDTH  divisor; sampled with start_i.
result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1.
ready_o  output  1  result valid (one END-state cycle).
stall_o  output  1  combinational stall request to the hazard unit.

Behaviour:
- Reset: rst=1 at an edge gives state=IDLE, cnt=0, result_o=0, ready_o=0, and clears internal registers. This applies from any state, mid-operation included.
- States: IDLE, BYZERO, ON, END.
- IDLE, start_i=1 and annul_i=0:
  - Latch the sign flags of both operands and signed_div_i.
  - Store magnitudes: two's-complement negation when signed and negative; raw values otherwise.
  - Divisor==0 goes to BYZERO (only with the optional feature, see below). Otherwise go to ON with cnt=0 and partial remainder=0.
- ON, per cycle:
  - Shift the partial remainder left by 1 and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude (WIDTH+1-bit subtract).
  - Non-negative result: keep the difference, quotient bit=1. Negative result: restore, quotient bit=0.
  - cnt increments. After the WIDTH-th iteration (cnt==WIDTH-1 on that edge), go to END.
- ON abort: annul_i=1 or start_i=0 sends the next state to IDLE. ready_o never asserts and the result is discarded.
- END:
  - Apply sign fix-up. The quotient is negated if the latched signs differ (signed only). The remainder is negated if the dividend was negative (signed only).
  - Register result_o and assert ready_o=1 for this cycle.
  - Next state is IDLE unconditionally. EX drops start_i in the same cycle it sees ready_o.
  - annul_i=1 in END: ready_o is still driven, but the next state is IDLE and EX ignores the result.
- Latency: the start edge is cycle 0. ready_o=1 in cycle WIDTH+1 (cycle 33 for the default).
- stall_o = start_i & ~annul_i & ~ready_o.
- A new start_i is accepted only in IDLE. Inputs are ignored in the other states.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0. No trap; the result wraps.
- Widths: magnitudes are WIDTH bits unsigned. result_o = {rem[WIDTH-1:0], quo[WIDTH-1:0]}.

Optional Feature:
DIV_ZERO_FAST_EN.
- Defined:
  - IDLE with divisor==0 goes to BYZERO.
  - BYZERO goes to END after 1 cycle with result_o forced to 0.
  - ready_o=1 in cycle 2.
- Undefined:
  - No BYZERO state. Divisor==0 runs the full WIDTH iterations.
  - The magnitude result is quotient=all ones, remainder=|dividend|, then the normal sign fix-up applies.
  - Example DIVU 5/0 gives LO=0xFFFFFFFF, HI=5 in cycle 33.

Test Plan:
1. DIVU 100/7, start held → stall_o=1 for cycles 0-32; cycle 33: ready_o=1, result_o={32'd2, 32'd14}; IDLE next cycle.
2. DIV -7/2 (0xFFFFFFF9, 0x00000002) → cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 → LO=0xFFFFFFFD, HI=0x00000001.
3. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0x00000000, no hang, ready_o in cycle 33.
4. Divide-by-zero DIVU 5/0:
   - With DIV_ZERO_FAST_EN: ready_o in cycle 2, result_o=0.
   - Without it: ready_o in cycle 33, LO=0xFFFFFFFF, HI=5.
5. DIVU 100/7, annul_i=1 at cycle 10 → IDLE at cycle 11, ready_o stays 0 throughout. Start DIVU 9/3 at cycle 12 → LO=3, HI=0 in cycle 45.
6. rst=1 at cycle 15 of a divide → next cycle: IDLE, ready_o=0, result_o=0. A start after reset completes normally.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Latency: result valid WIDTH+1 cycles after the accepting start edge (2 with fast divide-by-zero).
// Backpressure: stall_o holds the pipeline while start_i is up and no result is ready; no input queueing.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start_i         - divide request, held by EX until ready_o is seen
//   annul_i         - flush/exception, aborts a running divide
//   signed_div_i    - 1 = DIV, 0 = DIVU (sampled with start_i)
//   opdata1_i/2_i   - dividend / divisor (sampled with start_i)
//   result_o        - {remainder, quotient}, valid while ready_o=1
//   ready_o         - one-cycle result strobe (END state)
//   stall_o         - combinational stall request to the hazard unit
//
// Build option: define DIV_ZERO_FAST_EN to short-cut a zero divisor through
// the BYZERO state (result forced to 0). Without it, a zero divisor runs the
// full iteration count and yields quotient=all ones, remainder=|dividend|.

module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ON     = 2'b01,
    END    = 2'b10
`ifdef DIV_ZERO_FAST_EN
    , BYZERO = 2'b11
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out of the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;   // divisor magnitude
  logic             sdiv_q;  // latched signed_div_i
  logic             s1_q;    // latched dividend sign bit
  logic             s2_q;    // latched divisor sign bit

  // operand magnitudes at acceptance
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;

  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // one restoring iteration
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  // Sign fix-up is applied to the final iteration's outputs so the fixed
  // result is already sitting in result_o during the END cycle.
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign neg_quo = sdiv_q & (s1_q ^ s2_q);
  assign neg_rem = sdiv_q & s1_q;
  assign quo_fix = neg_quo ? -quo_nxt : quo_nxt;
  assign rem_fix = neg_rem ? -rem_nxt : rem_nxt;

  assign stall_o = start_i & ~annul_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            sdiv_q <= signed_div_i;
            s1_q   <= opdata1_i[WIDTH-1];
            s2_q   <= opdata2_i[WIDTH-1];
            quo_q  <= op1_mag;
            dvs_q  <= op2_mag;
            rem_q  <= '0;
            cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
            end
`else
            state  <= ON;
`endif
          end
        end

        ON: begin
          // EX withdrawing the request is treated like a flush
          if (annul_i || !start_i) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {rem_fix, quo_fix};
            end
          end
        end

`ifdef DIV_ZERO_FAST_EN
        BYZERO: begin
          state    <= END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
`endif

        END: begin
          // single-cycle strobe; an annul here just means EX drops the result
          ready_o <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sdiv;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int tests_run;
  int tests_failed;

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sdiv),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result),
    .ready_o      (ready),
    .stall_o      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests_run++;
    assert (obs === want)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Issue one divide at the next cycle boundary (cycle 0), hold start until
  // ready is seen, then check latency, stall, result and the drop of ready.
  task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] hi, input logic [31:0] lo);
    int cyc;
    int bad_stall;
    @(posedge clk); #1;
    sdiv  = sd;
    op1   = a;
    op2   = b;
    start = 1'b1;
    annul = 1'b0;
    cyc = 0;
    bad_stall = 0;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1) bad_stall++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_stall_while_busy"}, 64'(bad_stall), 64'd0);
    check({tag, "_stall_at_ready"}, {63'd0, stall}, 64'd0);
    check({tag, "_result"}, result, {hi, lo});
    start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_drops"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    int ready_seen;
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    sdiv  = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);

    // basic unsigned and signed cases
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_div("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'hFFFF_FFFE, 32'd14);
    do_div("divu_big_16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h0FFF_FFFF);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);

    // divide by zero
`ifdef DIV_ZERO_FAST_EN
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 32'd0, 32'd0);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 32'd0, 32'd0);
`else
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'h0000_0001);
`endif

    // annul at cycle 10 of a running divide
    ready_seen = 0;
    @(posedge clk); #1;
    sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    @(negedge clk);
    if (ready === 1'b1) ready_seen++;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 10) annul = 1'b1;
      @(negedge clk);
      if (ready === 1'b1) ready_seen++;
    end
    check("annul_stall_low", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    if (ready === 1'b1) ready_seen++;
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd0, 32'd3);

    // synchronous reset at cycle 15 of a running divide
    @(posedge clk); #1;
    sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 15) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    do_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
